branch_comp_iter: RTL
=====================

# branch_comp_iter

Iterative, parametrised branch comparator for the RV32I core's execute stage. It compares two XLEN-bit register operands one SLICE-bit slice per cycle, starting from the MSB slice. It supports signed and unsigned modes selected by funct3 and resolves the full RV32I branch decision (BEQ/BNE/BLT/BGE/BLTU/BGEU). Operands enter and results leave through valid/ready handshakes, so the unit can sit between the decoder and PC-select logic without timing-critical full-width compare paths.

## Interface
- XLEN, 32, operand width in bits
- SLICE, 4, bits compared per cycle; must divide XLEN, must be ≥1 (elaboration error otherwise)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  unit can accept a request; high exactly when state is IDLE
- funct3  input  3  branch funct3; bit pair [2:1]==2'b11 selects unsigned mode
- dataA  input  XLEN  rs1 value
- dataB  input  XLEN  rs2 value
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- br_eq  output  1  dataA == dataB
- br_lt  output  1  dataA < dataB, in the selected signedness
- br_taken  output  1  branch decision for the latched funct3
- br_illegal  output  1  latched funct3 was 010 or 011

## Operation
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, latch dataA, dataB and funct3, set slice index to N-1 (N = XLEN/SLICE), then go to SCAN.
  - SCAN: compare the latched slice at the current index.
    - Slices unequal: br_lt = (A_slice < B_slice) unsigned, br_eq=0, go to DONE. This exit depends on BRANCH_EARLY_EXIT_EN; see Configuration.
    - Index 0 reached with all slices equal: br_eq=1, br_lt=0, go to DONE.
    - Otherwise decrement the index and stay in SCAN.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Signed mode: bit XLEN-1 of both latched operands is inverted at latch time. The unsigned slice scan then yields the signed order. br_eq is unaffected.
- br_taken:
  - 000 → eq
  - 001 → ~eq
  - 100 and 110 → lt
  - 101 and 111 → ~lt
  - 010 and 011 → 0, with br_illegal=1. The scan still runs normally.
- br_eq, br_lt, br_taken and br_illegal are registered. They update only on entry to DONE and are held stable while out_valid & ~out_ready.
- A new request is never accepted in the DONE cycle, even when out_ready is high. in_ready rises the cycle after the result handshake.

## Timing
- Reset (rst_n low, any state, including mid-SCAN): state=IDLE. All outputs are 0 except in_ready=1. Any in-flight request is dropped with no result. No acceptance occurs while rst_n is low.
- Latency: out_valid rises k clock edges after the acceptance edge. k is the number of slices examined, 1..N.
- Throughput: one request per k+2 cycles when out_ready is held high.
- Boundary cases:
  - SLICE=XLEN: N=1, so k=1 always.
  - A difference only in slice 0: k=N in either configuration.
  - The index never wraps below 0.

## Configuration
- BRANCH_EARLY_EXIT_EN defined: SCAN exits at the first unequal slice, so k = N − (index of first differing slice from the top).
- Undefined: the scan always runs all N slices and k=N fixed. The first differing slice is recorded in a sticky flag and sets br_lt and br_eq. Results are identical in both configurations; only latency differs.

## Structure
- Shared package branch_pkg holds:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - state enum type br_state_t (IDLE, SCAN, DONE)
- One sub-module, slice_comp: combinational SLICE-bit unsigned compare with outputs eq and lt, instantiated once on the muxed current slice.

## Test plan
- BEQ, A=B=0x12345678 → out_valid 8 edges after accept, br_eq=1, br_lt=0, br_taken=1, br_illegal=0.
- BLT, A=0xFFFFFFFF, B=0x00000001 → br_lt=1, br_taken=1. k=1 with BRANCH_EARLY_EXIT_EN defined, k=8 without.
- BLTU, same operands → br_lt=0, br_eq=0, br_taken=0.
- BGE, A=0x00000010, B=0x00000011 → k=8 in both configurations, br_lt=1, br_taken=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0. Raise out_ready → in_ready=1 on the next cycle, and a new in_valid is accepted then.
- Reset and illegal funct3:
  - Drop rst_n mid-SCAN → all outputs 0 immediately, no out_valid after release.
  - Then funct3=010 with A=B=0 → br_illegal=1, br_taken=0, br_eq=1.

Source files
------------

// File: rtl/branch_comp_iter_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the iterative branch comparator:
//   - RV32I branch funct3 encodings
//   - FSM state type br_state_t (IDLE, SCAN, DONE)
//   - small decode helpers for funct3 (signedness, illegal, taken)
// ---------------------------------------------------------------------------
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } br_state_t;

  // funct3[2:1] == 2'b11 selects unsigned ordering (BLTU/BGEU).
  function automatic logic f3_is_unsigned(input logic [2:0] f3);
    return (f3[2:1] == 2'b11);
  endfunction

  // 010 and 011 are not branch encodings.
  function automatic logic f3_is_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

  function automatic logic f3_taken(input logic [2:0] f3,
                                    input logic       eq,
                                    input logic       lt);
    logic taken;
    case (f3)
      F3_BEQ:          taken = eq;
      F3_BNE:          taken = ~eq;
      F3_BLT, F3_BLTU: taken = lt;
      F3_BGE, F3_BGEU: taken = ~lt;
      default:         taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_comp_iter_if.sv
// ---------------------------------------------------------------------------
// branch_comp_iter_if
// Request/result bundle of the iterative branch comparator.
//   request : in_valid, in_ready, funct3, dataA, dataB
//   result  : out_valid, out_ready, br_eq, br_lt, br_taken, br_illegal
// Modports: master = requester/consumer side, slave = comparator side.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds valid and payload stable until that
// edge; ready may be asserted independently of valid. Result fields are
// stable for as long as out_valid is high.
// ---------------------------------------------------------------------------
interface branch_comp_iter_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dataA;
  logic [XLEN-1:0] dataB;
  logic            out_valid;
  logic            out_ready;
  logic            br_eq;
  logic            br_lt;
  logic            br_taken;
  logic            br_illegal;

  modport master (
    output in_valid, funct3, dataA, dataB, out_ready,
    input  in_ready, out_valid, br_eq, br_lt, br_taken, br_illegal
  );

  modport slave (
    input  in_valid, funct3, dataA, dataB, out_ready,
    output in_ready, out_valid, br_eq, br_lt, br_taken, br_illegal
  );
endinterface

// File: rtl/branch_comp_iter_slice_comp.sv
// ---------------------------------------------------------------------------
// slice_comp
// Combinational unsigned compare of one W-bit slice.
// Ports:
//   i_a, i_b : slice operands
//   o_eq     : i_a == i_b
//   o_lt     : i_a <  i_b (unsigned)
// ---------------------------------------------------------------------------
module slice_comp #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq,
  output logic         o_lt
);
  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a <  i_b);
endmodule

// File: rtl/branch_comp_iter.sv
// ---------------------------------------------------------------------------
// branch_comp_iter
// Iterative RV32I branch comparator. Compares two XLEN-bit operands one
// SLICE-bit slice per cycle from the MSB slice down and resolves
// BEQ/BNE/BLT/BGE/BLTU/BGEU.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : request/result handshake bundle (branch_comp_iter_if)
//   o_dbg_state  : current FSM state for observation
//
// Optional feature macro: BRANCH_EARLY_EXIT_EN
//   defined   : SCAN stops at the first unequal slice (variable latency)
//   undefined : SCAN always walks all N slices; the first difference is
//               kept in a sticky flag (fixed latency N). Results match.
// ---------------------------------------------------------------------------
module branch_comp_iter
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SLICE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_comp_iter_if.slave  bus,
  output br_state_t          o_dbg_state
);

  localparam int N     = (SLICE < 1) ? 1 : (XLEN / SLICE);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  generate
    if ((SLICE < 1) ? 1'b1 : ((XLEN % SLICE) != 0)) begin : g_bad_slice
      $error("branch_comp_iter: SLICE must be >= 1 and divide XLEN");
    end
  endgenerate

  br_state_t        r_state;
  br_state_t        w_next_state;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [2:0]       r_f3;
  logic [IDX_W-1:0] r_idx;
  logic             r_br_eq;
  logic             r_br_lt;
  logic             r_br_taken;
  logic             r_br_illegal;
`ifndef BRANCH_EARLY_EXIT_EN
  logic             r_found;   // an unequal slice has already been seen
  logic             r_lt_rec;  // slice order at that first difference
`endif

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic             w_s_eq;
  logic             w_s_lt;
  logic             w_accept;
  logic             w_finish;
  logic             w_fin_eq;
  logic             w_fin_lt;
  logic             w_last;
  logic [XLEN-1:0]  w_sign_flip;

  assign w_a_slice = r_a[r_idx*SLICE +: SLICE];
  assign w_b_slice = r_b[r_idx*SLICE +: SLICE];
  assign w_last    = (r_idx == '0);

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so the slice scan itself is always unsigned.
  assign w_sign_flip = {~f3_is_unsigned(bus.funct3), {(XLEN-1){1'b0}}};

  slice_comp #(.W(SLICE)) u_slice_comp (
    .i_a  (w_a_slice),
    .i_b  (w_b_slice),
    .o_eq (w_s_eq),
    .o_lt (w_s_lt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and scan decisions
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_fin_eq     = 1'b0;
    w_fin_lt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_next_state = SCAN;
        end
      end
      SCAN: begin
`ifdef BRANCH_EARLY_EXIT_EN
        if (!w_s_eq) begin
          w_finish = 1'b1;
          w_fin_eq = 1'b0;
          w_fin_lt = w_s_lt;
        end else if (w_last) begin
          w_finish = 1'b1;
          w_fin_eq = 1'b1;
          w_fin_lt = 1'b0;
        end
`else
        if (w_last) begin
          w_finish = 1'b1;
          if (r_found) begin
            w_fin_eq = 1'b0;
            w_fin_lt = r_lt_rec;
          end else begin
            w_fin_eq = w_s_eq;
            w_fin_lt = w_s_lt;
          end
        end
`endif
        if (w_finish) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        // No acceptance here: IDLE is always visited between results.
        if (bus.out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand latch, slice index and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_f3         <= '0;
      r_idx        <= '0;
      r_br_eq      <= 1'b0;
      r_br_lt      <= 1'b0;
      r_br_taken   <= 1'b0;
      r_br_illegal <= 1'b0;
`ifndef BRANCH_EARLY_EXIT_EN
      r_found      <= 1'b0;
      r_lt_rec     <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a      <= bus.dataA ^ w_sign_flip;
        r_b      <= bus.dataB ^ w_sign_flip;
        r_f3     <= bus.funct3;
        r_idx    <= IDX_W'(N - 1);
`ifndef BRANCH_EARLY_EXIT_EN
        r_found  <= 1'b0;
        r_lt_rec <= 1'b0;
`endif
      end else if ((r_state == SCAN) && !w_finish) begin
        // Only reached with r_idx > 0, so the index never wraps.
        r_idx <= r_idx - 1'b1;
`ifndef BRANCH_EARLY_EXIT_EN
        if (!r_found && !w_s_eq) begin
          r_found  <= 1'b1;
          r_lt_rec <= w_s_lt;
        end
`endif
      end
      if (w_finish) begin
        r_br_eq      <= w_fin_eq;
        r_br_lt      <= w_fin_lt;
        r_br_taken   <= f3_taken(r_f3, w_fin_eq, w_fin_lt);
        r_br_illegal <= f3_is_illegal(r_f3);
      end
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.br_eq      = r_br_eq;
  assign bus.br_lt      = r_br_lt;
  assign bus.br_taken   = r_br_taken;
  assign bus.br_illegal = r_br_illegal;
  assign o_dbg_state    = r_state;

endmodule
